// File: rtl/clock_pkg.sv
// Shared definitions for the hour display path.
//   BLANK_CODE  : digit code that drives a dark 7-segment position
//   db_state_t  : mode push-button debounce states
//   HOUR_MAX    : largest legal 24-h hour
//   HOUR12      : first PM hour / 12-h wrap point
package clock_pkg;

   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam logic [7:0] HOUR_MAX   = 8'd23;
   localparam logic [7:0] HOUR12     = 8'd12;

   typedef enum logic [1:0] {
      DB_IDLE      = 2'd0,
      DB_ARMING    = 2'd1,
      DB_HELD      = 2'd2,
      DB_RELEASING = 2'd3
   } db_state_t;

endpackage

// File: rtl/mode_debounce.sv
// Synchronises and debounces the 24/12 mode push button.
//   CP     : clock
//   nCR    : async active-low reset
//   Ctrl   : raw button, active-high, asynchronous to CP
//   toggle : one-cycle pulse on an accepted press (ARMING->HELD)
//
// state      | meaning
// -----------+------------------------------------------------
// IDLE       | button released and stable
// ARMING     | counting consecutive 1s toward an accepted press
// HELD       | press accepted, waiting for release
// RELEASING  | counting consecutive 0s toward an accepted release
module mode_debounce
   import clock_pkg::*;
#(
   parameter int DB_CYC = 16
) (
   input  logic CP,
   input  logic nCR,
   input  logic Ctrl,
   output logic toggle
);

   localparam int CW = $clog2(DB_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(DB_CYC);

   logic            sync1, sync2;
   db_state_t       state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [CW-1:0]   cnt_inc;

   // Saturating increment: the counter parks at DB_CYC instead of wrapping.
   assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      toggle   = 1'b0;
      case (state)
         DB_IDLE: begin
            cnt_nx = '0;
            if (sync2) begin
               state_nx = DB_ARMING;
               cnt_nx   = CW'(1);
            end
         end
         DB_ARMING: begin
            if (!sync2) begin
               state_nx = DB_IDLE;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = DB_HELD;
               cnt_nx   = '0;
               toggle   = 1'b1;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         DB_HELD: begin
            cnt_nx = '0;
            if (!sync2) begin
               state_nx = DB_RELEASING;
               cnt_nx   = CW'(1);
            end
         end
         DB_RELEASING: begin
            if (sync2) begin
               state_nx = DB_HELD;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = DB_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         default: begin
            state_nx = DB_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= DB_IDLE;
         cnt   <= '0;
      end else begin
         sync1 <= Ctrl;
         sync2 <= sync1;
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

endmodule

// File: rtl/hour_format_conv.sv
// 24-h / 12-h hour display converter, NCH independent channels, shared mode.
//   CP, nCR        : clock, async active-low reset
//   Ctrl           : raw mode push button (debounced internally)
//   InValid        : CLH/CLL carry a new sample
//   CLH, CLL       : BCD hour tens/units, channel k at [4k+3:4k]
//   DispH, DispL   : converted tens/units (tens may be BLANK_CODE in 12-h)
//   PM             : hour >= 12 per channel
//   Mode12         : 0 = 24-h, 1 = 12-h
//   OutValid       : outputs updated this cycle (one cycle after InValid)
//   Err            : last sample of that channel was not a legal hour
module hour_format_conv
   import clock_pkg::*;
#(
   parameter int NCH      = 1,
   parameter int DB_CYC   = 16,
   parameter int LZ_BLANK = 1
) (
   input  logic             CP,
   input  logic             nCR,
   input  logic             Ctrl,
   input  logic             InValid,
   input  logic [4*NCH-1:0] CLH,
   input  logic [4*NCH-1:0] CLL,
   output logic [4*NCH-1:0] DispH,
   output logic [4*NCH-1:0] DispL,
   output logic [NCH-1:0]   PM,
   output logic             Mode12,
   output logic             OutValid,
   output logic [NCH-1:0]   Err
);

   logic toggle;

   mode_debounce #(.DB_CYC(DB_CYC)) u_debounce (
      .CP     (CP),
      .nCR    (nCR),
      .Ctrl   (Ctrl),
      .toggle (toggle)
   );

   // Mode flips on the same edge that samples InValid, so a coincident
   // sample is converted with the old mode.
   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         Mode12   <= 1'b0;
         OutValid <= 1'b0;
      end else begin
         Mode12   <= Mode12 ^ toggle;
         OutValid <= InValid;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [3:0] th, tl;
      logic [7:0] h;
      logic [4:0] h12;
      logic       legal, pm_c, tens;
      logic [3:0] dh, dl;
      logic [3:0] dh_q, dl_q;
      logic       pm_q, err_q;

      always_comb begin
         th    = CLH[4*k +: 4];
         tl    = CLL[4*k +: 4];
         h     = (8'(th) * 8'd10) + 8'(tl);
         legal = (th <= 4'd2) && (tl <= 4'd9) && (h <= HOUR_MAX);
         pm_c  = (h >= HOUR12);
         if (h == 8'd0)        h12 = 5'(HOUR12);
         else if (h > HOUR12)  h12 = 5'(h - HOUR12);
         else                  h12 = h[4:0];
         tens = (h12 >= 5'd10);
         if (Mode12) begin
            dl = tens ? 4'(h12 - 5'd10) : h12[3:0];
            if (tens)                dh = 4'd1;
            else if (LZ_BLANK != 0)  dh = BLANK_CODE;
            else                     dh = 4'd0;
         end else begin
            dh = th;
            dl = tl;
         end
      end

      // Illegal samples flag Err but leave this channel's digits/PM untouched.
      always_ff @(posedge CP or negedge nCR) begin
         if (!nCR) begin
            dh_q  <= 4'd0;
            dl_q  <= 4'd0;
            pm_q  <= 1'b0;
            err_q <= 1'b0;
         end else if (InValid) begin
            err_q <= ~legal;
            if (legal) begin
               dh_q <= dh;
               dl_q <= dl;
               pm_q <= pm_c;
            end
         end
      end

      assign DispH[4*k +: 4] = dh_q;
      assign DispL[4*k +: 4] = dl_q;
      assign PM[k]           = pm_q;
      assign Err[k]          = err_q;
   end

endmodule
